// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - CRC-32 (IEEE 802.3) constants, FSM state type and reflected byte update
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } crc_state_e;

  // Reflected update: data enters LSB first, register shifts right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lanes.sv
// rtl/crc32_lanes.sv - combinational fold of KW byte lanes into a CRC-32 register
module crc32_lanes
  import crc32_pkg::*;
#(
  parameter int DW = 32,
  localparam int KW = DW / 8
) (
  input  logic [31:0]   crc_in,
  input  logic [DW-1:0] data,
  input  logic [KW-1:0] keep,
  output logic [31:0]   crc_out
);

  // Lane 0 is the first byte on the wire, so it is folded first.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < KW; i++) begin
      if (keep[i]) begin
        c = crc32_byte(c, data[8*i +: 8]);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc32_stream.sv
// rtl/crc32_stream.sv - streaming CRC-32 engine; CRC_STREAM_STATS_EN adds good/bad frame counters
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DW = 32,
  localparam int KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          crc_clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [KW-1:0] s_keep,
  input  logic          s_last,
  output logic [31:0]   crc_run,
  output logic          res_valid,
  input  logic          res_ready,
`ifdef CRC_STREAM_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_good,
  output logic [15:0]   stat_bad,
`endif
  output logic [31:0]   res_crc,
  output logic          res_ok,
  output logic          res_keep_err
);

  crc_state_e    state;
  logic          s_ready_q;
  logic          err_q;
  logic          xfer;
  logic          beat_err;
  logic [KW-1:0] keep_inc;
  logic          keep_contig;
  logic [31:0]   next_crc;

  // Registered ready, gated only by the abort so a clr cycle never accepts a beat.
  assign s_ready = s_ready_q & ~crc_clr;
  assign xfer    = s_valid & s_ready;

  // keep is a low-order run of ones iff adding one clears every set bit.
  assign keep_inc    = s_keep + KW'(1);
  assign keep_contig = ((s_keep & keep_inc) == '0);
  assign beat_err    = s_last ? ~keep_contig : ~(&s_keep);

  crc32_lanes #(.DW(DW)) u_lanes (
    .crc_in  (crc_run),
    .data    (s_data),
    .keep    (s_keep),
    .crc_out (next_crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACC;
      s_ready_q    <= 1'b1;
      crc_run      <= CRC32_INIT;
      err_q        <= 1'b0;
      res_valid    <= 1'b0;
      res_crc      <= 32'h0;
      res_ok       <= 1'b0;
      res_keep_err <= 1'b0;
    end else if (crc_clr) begin
      state     <= ACC;
      s_ready_q <= 1'b1;
      crc_run   <= CRC32_INIT;
      err_q     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (xfer) begin
            if (s_last) begin
              res_crc      <= next_crc ^ CRC32_XOROUT;
              res_ok       <= (next_crc == CRC32_RESIDUE);
              res_keep_err <= err_q | beat_err;
              res_valid    <= 1'b1;
              crc_run      <= CRC32_INIT;
              err_q        <= 1'b0;
              s_ready_q    <= 1'b0;
              state        <= HOLD;
            end else begin
              crc_run <= next_crc;
              if (beat_err) begin
                err_q <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef CRC_STREAM_STATS_EN
  logic res_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_d <= 1'b0;
      stat_good   <= 16'h0;
      stat_bad    <= 16'h0;
    end else begin
      res_valid_d <= res_valid;
      if (stat_clr) begin
        stat_good <= 16'h0;
        stat_bad  <= 16'h0;
      end else if (res_valid && !res_valid_d) begin
        if (res_ok && !res_keep_err) begin
          if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'h1;
        end else begin
          if (stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'h1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// tb/tb_crc32_stream.sv - directed bench for crc32_stream at DW=8, 32 and 64
module tb_crc32_stream;

  logic clk;
  logic rst;
  logic crc_clr;

  logic        s_valid_8, s_ready_8, s_last_8, res_valid_8, res_ready_8, res_ok_8, res_keep_err_8;
  logic [7:0]  s_data_8;
  logic [0:0]  s_keep_8;
  logic [31:0] crc_run_8, res_crc_8;

  logic        s_valid_32, s_ready_32, s_last_32, res_valid_32, res_ready_32, res_ok_32, res_keep_err_32;
  logic [31:0] s_data_32;
  logic [3:0]  s_keep_32;
  logic [31:0] crc_run_32, res_crc_32;

  logic        s_valid_64, s_ready_64, s_last_64, res_valid_64, res_ready_64, res_ok_64, res_keep_err_64;
  logic [63:0] s_data_64;
  logic [7:0]  s_keep_64;
  logic [31:0] crc_run_64, res_crc_64;

  int checks;
  int errors;

  crc32_stream #(.DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr),
    .s_valid(s_valid_8), .s_ready(s_ready_8), .s_data(s_data_8), .s_keep(s_keep_8), .s_last(s_last_8),
    .crc_run(crc_run_8), .res_valid(res_valid_8), .res_ready(res_ready_8),
    .res_crc(res_crc_8), .res_ok(res_ok_8), .res_keep_err(res_keep_err_8)
  );

  crc32_stream #(.DW(32)) u_dut32 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr),
    .s_valid(s_valid_32), .s_ready(s_ready_32), .s_data(s_data_32), .s_keep(s_keep_32), .s_last(s_last_32),
    .crc_run(crc_run_32), .res_valid(res_valid_32), .res_ready(res_ready_32),
    .res_crc(res_crc_32), .res_ok(res_ok_32), .res_keep_err(res_keep_err_32)
  );

  crc32_stream #(.DW(64)) u_dut64 (
    .clk(clk), .rst(rst), .crc_clr(crc_clr),
    .s_valid(s_valid_64), .s_ready(s_ready_64), .s_data(s_data_64), .s_keep(s_keep_64), .s_last(s_last_64),
    .crc_run(crc_run_64), .res_valid(res_valid_64), .res_ready(res_ready_64),
    .res_crc(res_crc_64), .res_ok(res_ok_64), .res_keep_err(res_keep_err_64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rvalid(input int w);
    case (w)
      8:       return res_valid_8;
      64:      return res_valid_64;
      default: return res_valid_32;
    endcase
  endfunction

  function automatic logic [31:0] rcrc(input int w);
    case (w)
      8:       return res_crc_8;
      64:      return res_crc_64;
      default: return res_crc_32;
    endcase
  endfunction

  function automatic logic rkerr(input int w);
    case (w)
      8:       return res_keep_err_8;
      64:      return res_keep_err_64;
      default: return res_keep_err_32;
    endcase
  endfunction

  task automatic drive(input int w, input logic [63:0] d, input logic [7:0] k, input logic v, input logic l);
    case (w)
      8:       begin s_valid_8 = v;  s_data_8 = d[7:0];   s_keep_8 = k[0:0];  s_last_8 = l;  end
      64:      begin s_valid_64 = v; s_data_64 = d;       s_keep_64 = k;      s_last_64 = l; end
      default: begin s_valid_32 = v; s_data_32 = d[31:0]; s_keep_32 = k[3:0]; s_last_32 = l; end
    endcase
  endtask

  // Presents one beat for one clock; the engine is in ACC so it transfers on that edge.
  task automatic beat(input int w, input logic [63:0] d, input logic [7:0] k, input logic l);
    drive(w, d, k, 1'b1, l);
    @(negedge clk);
    drive(w, 64'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_res(input int w, output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid(w)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(input int w);
    case (w)
      8:       res_ready_8 = 1'b1;
      64:      res_ready_64 = 1'b1;
      default: res_ready_32 = 1'b1;
    endcase
    @(negedge clk);
    res_ready_8 = 1'b0; res_ready_32 = 1'b0; res_ready_64 = 1'b0;
  endtask

  task automatic send_check32();
    beat(32, 64'h34333231, 8'hF, 1'b0);
    beat(32, 64'h38373635, 8'hF, 1'b0);
    beat(32, 64'h00000039, 8'h1, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (crc_run_32 !== 32'hFFFFFFFF || s_ready_32 !== 1'b1) begin
      errors++; $display("FAIL reset_run_ready: crc_run=%h s_ready=%b, want ffffffff 1", crc_run_32, s_ready_32);
    end
    checks++;
    if (res_valid_32 !== 1'b0 || res_crc_32 !== 32'h0 || res_ok_32 !== 1'b0 || res_keep_err_32 !== 1'b0) begin
      errors++; $display("FAIL reset_res: valid=%b crc=%h ok=%b kerr=%b, want 0 0 0 0",
                         res_valid_32, res_crc_32, res_ok_32, res_keep_err_32);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dw8();
    bit got;
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) beat(8, {56'h0, msg[i]}, 8'h1, (i == 8));
    wait_res(8, got);
    checks++;
    if (!got || res_crc_8 !== 32'hCBF43926 || res_keep_err_8 !== 1'b0) begin
      errors++; $display("FAIL dw8_check_value: valid=%b crc=%h kerr=%b, want 1 cbf43926 0", got, res_crc_8, res_keep_err_8);
    end
    consume(8);
  endtask

  task automatic test_dw32();
    bit got;
    send_check32();
    wait_res(32, got);
    checks++;
    if (!got || res_crc_32 !== 32'hCBF43926 || res_keep_err_32 !== 1'b0 || res_ok_32 !== 1'b0) begin
      errors++; $display("FAIL dw32_check_value: valid=%b crc=%h kerr=%b ok=%b, want 1 cbf43926 0 0",
                         got, res_crc_32, res_keep_err_32, res_ok_32);
    end
    consume(32);
  endtask

  task automatic test_dw64();
    bit got;
    beat(64, 64'h3837363534333231, 8'hFF, 1'b0);
    beat(64, 64'h0000000000000039, 8'h01, 1'b1);
    wait_res(64, got);
    checks++;
    if (!got || res_crc_64 !== 32'hCBF43926 || res_keep_err_64 !== 1'b0) begin
      errors++; $display("FAIL dw64_check_value: valid=%b crc=%h kerr=%b, want 1 cbf43926 0", got, res_crc_64, res_keep_err_64);
    end
    consume(64);
  endtask

  task automatic test_residue();
    bit got;
    beat(32, 64'h34333231, 8'hF, 1'b0);
    beat(32, 64'h38373635, 8'hF, 1'b0);
    beat(32, 64'hF4392639, 8'hF, 1'b0);
    beat(32, 64'h000000CB, 8'h1, 1'b1);
    wait_res(32, got);
    checks++;
    if (!got || res_ok_32 !== 1'b1 || res_crc_32 !== 32'h2144DF1C) begin
      errors++; $display("FAIL residue_good: valid=%b ok=%b crc=%h, want 1 1 2144df1c", got, res_ok_32, res_crc_32);
    end
    consume(32);
    beat(32, 64'h35333231, 8'hF, 1'b0);
    beat(32, 64'h38373635, 8'hF, 1'b0);
    beat(32, 64'hF4392639, 8'hF, 1'b0);
    beat(32, 64'h000000CB, 8'h1, 1'b1);
    wait_res(32, got);
    checks++;
    if (!got || res_ok_32 !== 1'b0) begin
      errors++; $display("FAIL residue_corrupt: valid=%b ok=%b, want 1 0", got, res_ok_32);
    end
    consume(32);
  endtask

  task automatic test_backpressure();
    bit got;
    send_check32();
    wait_res(32, got);
    drive(32, 64'hDEADBEEF, 8'hF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!got || s_ready_32 !== 1'b0 || res_valid_32 !== 1'b1 || res_crc_32 !== 32'hCBF43926) begin
        errors++; $display("FAIL hold_cycle%0d: s_ready=%b valid=%b crc=%h, want 0 1 cbf43926",
                           i, s_ready_32, res_valid_32, res_crc_32);
      end
      @(negedge clk);
    end
    drive(32, 64'h0, 8'h0, 1'b0, 1'b0);
    checks++;
    if (crc_run_32 !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL hold_no_fold: crc_run=%h, want ffffffff", crc_run_32);
    end
    consume(32);
    checks++;
    if (res_valid_32 !== 1'b0 || s_ready_32 !== 1'b1) begin
      errors++; $display("FAIL release: valid=%b s_ready=%b, want 0 1", res_valid_32, s_ready_32);
    end
  endtask

  task automatic test_boundaries();
    bit got;
    beat(32, 64'h0, 8'h0, 1'b1);
    wait_res(32, got);
    checks++;
    if (!got || res_crc_32 !== 32'h00000000 || res_keep_err_32 !== 1'b0) begin
      errors++; $display("FAIL empty_frame: valid=%b crc=%h kerr=%b, want 1 00000000 0", got, res_crc_32, res_keep_err_32);
    end
    consume(32);
    beat(32, 64'h00333231, 8'h7, 1'b0);
    beat(32, 64'h00000034, 8'h1, 1'b1);
    wait_res(32, got);
    checks++;
    if (!got || res_keep_err_32 !== 1'b1) begin
      errors++; $display("FAIL keep_nonlast: valid=%b kerr=%b, want 1 1", got, res_keep_err_32);
    end
    consume(32);
    beat(32, 64'h34333231, 8'hF, 1'b0);
    beat(32, 64'h00350036, 8'h5, 1'b1);
    wait_res(32, got);
    checks++;
    if (!got || res_keep_err_32 !== 1'b1) begin
      errors++; $display("FAIL keep_last_gap: valid=%b kerr=%b, want 1 1", got, res_keep_err_32);
    end
    consume(32);
    send_check32();
    wait_res(32, got);
    checks++;
    if (!got || res_keep_err_32 !== 1'b0 || res_crc_32 !== 32'hCBF43926) begin
      errors++; $display("FAIL err_cleared: valid=%b kerr=%b crc=%h, want 1 0 cbf43926", got, res_keep_err_32, res_crc_32);
    end
    consume(32);
  endtask

  task automatic test_abort();
    bit got;
    beat(32, 64'h34333231, 8'hF, 1'b0);
    drive(32, 64'h38373635, 8'hF, 1'b1, 1'b1);
    crc_clr = 1'b1;
    #1;
    checks++;
    if (s_ready_32 !== 1'b0) begin
      errors++; $display("FAIL clr_ready: s_ready=%b, want 0", s_ready_32);
    end
    @(negedge clk);
    crc_clr = 1'b0;
    drive(32, 64'h0, 8'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (crc_run_32 !== 32'hFFFFFFFF || res_valid_32 !== 1'b0) begin
      errors++; $display("FAIL clr_state: crc_run=%h valid=%b, want ffffffff 0", crc_run_32, res_valid_32);
    end
    send_check32();
    wait_res(32, got);
    checks++;
    if (!got || res_crc_32 !== 32'hCBF43926) begin
      errors++; $display("FAIL after_clr: valid=%b crc=%h, want 1 cbf43926", got, res_crc_32);
    end
    consume(32);
  endtask

  task automatic test_reset_midframe();
    beat(32, 64'h34333231, 8'hF, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (crc_run_32 !== 32'hFFFFFFFF || res_valid_32 !== 1'b0) begin
      errors++; $display("FAIL rst_midframe: crc_run=%h valid=%b, want ffffffff 0", crc_run_32, res_valid_32);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (res_valid_32 !== 1'b0 || s_ready_32 !== 1'b1) begin
      errors++; $display("FAIL rst_no_result: valid=%b s_ready=%b, want 0 1", res_valid_32, s_ready_32);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    crc_clr = 1'b0;
    res_ready_8 = 1'b0; res_ready_32 = 1'b0; res_ready_64 = 1'b0;
    drive(8, 64'h0, 8'h0, 1'b0, 1'b0);
    drive(32, 64'h0, 8'h0, 1'b0, 1'b0);
    drive(64, 64'h0, 8'h0, 1'b0, 1'b0);
    test_reset();
    test_dw8();
    test_dw32();
    test_dw64();
    test_residue();
    test_backpressure();
    test_boundaries();
    test_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
